// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - field handshake and instruction-memory write port bundle
interface instruction_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            in_opcode;
  logic [4:0]            in_rs;
  logic [4:0]            in_rt;
  logic [4:0]            in_rd;
  logic [15:0]           in_imm;
  logic                  in_last;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs decoded instruction fields into imem words and appends EOF
module instruction_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instruction_encoder_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {IDLE, RUN, EOFW, DONE, ERR} state_t;

  localparam logic [5:0]            OP_EOF   = 6'd12;
  localparam logic [31:0]           EOF_WORD = {OP_EOF, 26'b0};
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  wr_en;
  logic [31:0]           wr_word;
  logic                  transfer;
  logic                  is_rtype, is_itype;

  always_comb begin
    is_rtype = 1'b0;
    is_itype = 1'b0;
    case (bus.in_opcode)
      6'd1, 6'd2, 6'd6, 6'd7, 6'd8, 6'd11: is_rtype = 1'b1;
      6'd3, 6'd4, 6'd5, 6'd9, 6'd10:       is_itype = 1'b1;
      default: ;
    endcase
  end

  assign transfer = bus.in_valid && (state == RUN);

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_word    = 32'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (transfer) begin
          if (bus.in_opcode == OP_EOF) begin
            wr_en      = 1'b1;
            wr_word    = EOF_WORD;
            state_next = DONE;
          end else if (!is_rtype && !is_itype) begin
            state_next = ERR;
          end else if (ptr == LAST_PTR) begin
            // last slot is held back for the EOF word
            state_next = ERR;
          end else begin
            wr_en      = 1'b1;
            wr_word    = is_rtype
                       ? {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_rd, 11'b0}
                       : {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
            state_next = bus.in_last ? EOFW : RUN;
          end
        end
      end
      EOFW: begin
        wr_en      = 1'b1;
        wr_word    = EOF_WORD;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      word_count     <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'b0;
    end else begin
      state       <= state_next;
      bus.imem_we <= wr_en;
      if (wr_en) begin
        bus.imem_addr  <= ptr;
        bus.imem_wdata <= wr_word;
        ptr            <= ptr + 1'b1;
        word_count     <= word_count + 1'b1;
      end
      if ((state == IDLE || state == DONE || state == ERR) && start) begin
        ptr        <= '0;
        word_count <= '0;
      end
    end
  end

  assign bus.in_ready = (state == RUN);
  assign busy         = (state == RUN) || (state == EOFW);
  assign done         = (state == DONE);
  assign err          = (state == ERR);

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed checks of instruction_encoder at DEPTH 256 and DEPTH 4
module tb_instruction_encoder;
  logic clk = 1'b0;
  logic reset, start_a, start_b;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [8:0] wc_a;
  logic [2:0] wc_b;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instruction_encoder_if #(.ADDR_WIDTH(8)) ifa ();
  instruction_encoder_if #(.ADDR_WIDTH(2)) ifb ();

  instruction_encoder #(.ADDR_WIDTH(8), .DEPTH(256)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(ifa.slave),
    .busy(busy_a), .done(done_a), .err(err_a), .word_count(wc_a));

  instruction_encoder #(.ADDR_WIDTH(2), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(ifb.slave),
    .busy(busy_b), .done(done_b), .err(err_b), .word_count(wc_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last);
    ifa.in_valid = 1'b1; ifa.in_opcode = op; ifa.in_rs = rs; ifa.in_rt = rt;
    ifa.in_rd = rd; ifa.in_imm = imm; ifa.in_last = last;
  endtask

  task automatic send_b(input logic [5:0] op);
    ifb.in_valid = 1'b1; ifb.in_opcode = op; ifb.in_rs = 5'd1; ifb.in_rt = 5'd2;
    ifb.in_rd = 5'd3; ifb.in_imm = 16'h0; ifb.in_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    send_a(6'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0); ifa.in_valid = 1'b0;
    send_b(6'd0); ifb.in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0); chk("rst_err", err_a, 0);
    chk("rst_ready", ifa.in_ready, 0); chk("rst_we", ifa.imem_we, 0);
    chk("rst_addr", ifa.imem_addr, 0); chk("rst_wdata", ifa.imem_wdata, 0); chk("rst_wc", wc_a, 0);

    // add with masked immediate
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("run_busy", busy_a, 1); chk("run_ready", ifa.in_ready, 1); chk("run_we", ifa.imem_we, 0);
    send_a(6'd1, 5'd1, 5'd2, 5'd3, 16'hFFFF, 1'b0); step(); ifa.in_valid = 1'b0;
    chk("add_we", ifa.imem_we, 1); chk("add_addr", ifa.imem_addr, 0);
    chk("add_data", ifa.imem_wdata, 32'h04221800); chk("add_wc", wc_a, 1);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("start_ign_wc", wc_a, 1); chk("idle_we", ifa.imem_we, 0);
    send_a(6'd12, 5'd7, 5'd7, 5'd7, 16'h1234, 1'b0); step(); ifa.in_valid = 1'b0;
    chk("eof1_addr", ifa.imem_addr, 1); chk("eof1_data", ifa.imem_wdata, 32'h30000000);
    chk("eof1_done", done_a, 1); chk("eof1_wc", wc_a, 2);

    // addi, sw(last) back to back then automatic EOF
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("restart_done", done_a, 0); chk("restart_wc", wc_a, 0);
    send_a(6'd3, 5'd0, 5'd5, 5'd9, 16'h0010, 1'b0); step();
    chk("addi_we", ifa.imem_we, 1); chk("addi_addr", ifa.imem_addr, 0);
    chk("addi_data", ifa.imem_wdata, 32'h0C050010);
    send_a(6'd5, 5'd2, 5'd3, 5'd9, 16'h0004, 1'b1); step(); ifa.in_valid = 1'b0;
    chk("sw_we", ifa.imem_we, 1); chk("sw_addr", ifa.imem_addr, 1);
    chk("sw_data", ifa.imem_wdata, 32'h14430004);
    chk("eofw_busy", busy_a, 1); chk("eofw_ready", ifa.in_ready, 0); chk("eofw_done", done_a, 0);
    step();
    chk("eof2_we", ifa.imem_we, 1); chk("eof2_addr", ifa.imem_addr, 2);
    chk("eof2_data", ifa.imem_wdata, 32'h30000000);
    chk("eof2_done", done_a, 1); chk("eof2_wc", wc_a, 3); chk("eof2_busy", busy_a, 0);
    step();
    chk("post_we", ifa.imem_we, 0);

    // beq with negative offset, explicit EOF
    start_a = 1'b1; step(); start_a = 1'b0;
    send_a(6'd9, 5'd1, 5'd1, 5'd4, 16'hFFFE, 1'b0); step();
    chk("beq_addr", ifa.imem_addr, 0); chk("beq_data", ifa.imem_wdata, 32'h2421FFFE);
    send_a(6'd12, 5'd31, 5'd31, 5'd31, 16'hFFFF, 1'b0); step(); ifa.in_valid = 1'b0;
    chk("eof3_addr", ifa.imem_addr, 1); chk("eof3_data", ifa.imem_wdata, 32'h30000000);
    chk("eof3_done", done_a, 1); chk("eof3_wc", wc_a, 2); chk("eof3_ready", ifa.in_ready, 0);

    // illegal opcode, recovery
    start_a = 1'b1; step(); start_a = 1'b0;
    send_a(6'd13, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0); step(); ifa.in_valid = 1'b0;
    chk("ill_we", ifa.imem_we, 0); chk("ill_err", err_a, 1);
    chk("ill_ready", ifa.in_ready, 0); chk("ill_wc", wc_a, 0); chk("ill_busy", busy_a, 0);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("clr_err", err_a, 0);
    send_a(6'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0); step();
    chk("rec_we", ifa.imem_we, 1); chk("rec_addr", ifa.imem_addr, 0);
    chk("rec_data", ifa.imem_wdata, 32'h04221800);
    send_a(6'd11, 5'd4, 5'd5, 5'd6, 16'hABCD, 1'b0); step();
    chk("slt_addr", ifa.imem_addr, 1); chk("slt_data", ifa.imem_wdata, 32'h2C853000);

    // and with last, then reset while in EOFW
    send_a(6'd6, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1); step(); ifa.in_valid = 1'b0;
    chk("and_addr", ifa.imem_addr, 2); chk("and_data", ifa.imem_wdata, 32'h18221800);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstm_we", ifa.imem_we, 0); chk("rstm_busy", busy_a, 0); chk("rstm_done", done_a, 0);
    chk("rstm_wc", wc_a, 0); chk("rstm_addr", ifa.imem_addr, 0); chk("rstm_data", ifa.imem_wdata, 0);
    step();
    chk("rstm_ready", ifa.in_ready, 0); chk("rstm_we2", ifa.imem_we, 0);

    // capacity on DEPTH=4 instance
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_b(6'd1); step();
      chk("cap_we", ifb.imem_we, 1); chk("cap_addr", ifb.imem_addr, 32'(i));
    end
    send_b(6'd2); step(); ifb.in_valid = 1'b0;
    chk("ovf_we", ifb.imem_we, 0); chk("ovf_err", err_b, 1); chk("ovf_wc", wc_b, 3);
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_b(6'd1); step();
      chk("cap2_addr", ifb.imem_addr, 32'(i));
    end
    send_b(6'd12); step(); ifb.in_valid = 1'b0;
    chk("full_we", ifb.imem_we, 1); chk("full_addr", ifb.imem_addr, 3);
    chk("full_data", ifb.imem_wdata, 32'h30000000);
    chk("full_done", done_b, 1); chk("full_err", err_b, 0); chk("full_wc", wc_b, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
